// File: rtl/conv1d_line_mac_if.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_line_mac_if
// Brief    : Result stream (valid/ready) plus end-of-line pulse of conv1d_line_mac.
// Revision : 1.0 - initial release
// ============================================================================
interface conv1d_line_mac_if #(
    parameter int DW       = 16,
    parameter int MEM_ADDR = 4
);
    logic                       out_valid;
    logic                       out_ready;
    logic signed [DW-1:0]       out_data;
    logic        [MEM_ADDR-1:0] out_idx;
    logic                       done;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output done,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  done,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/conv1d_line_mac.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_line_mac
// Brief    : Fetches one line from the line memory, convolves it with a KW-tap
//            kernel using one MAC per clock and streams rounded, saturated
//            results. Define RELU_EN to clamp negative results to zero.
// Revision : 1.0 - initial release
// ============================================================================
module conv1d_line_mac #(
    parameter int DW        = 16,
    parameter int MEM_SIZE  = 10,
    parameter int MEM_ADDR  = 4,
    parameter int KW        = 3,
    parameter int OUT_SHIFT = 8,
    parameter int ACC_W     = 2*DW+4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [KW*DW-1:0]       kernel_in,
    output logic                   rd_en,
    input  logic [MEM_SIZE*DW-1:0] line_in,
    output logic                   busy,
    conv1d_line_mac_if.master      out_if
);

    localparam int c_NOUT = MEM_SIZE - KW + 1;
    localparam int c_TW   = (KW > 1) ? $clog2(KW) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_MAC   = 2'd2;
    localparam logic [1:0] c_OUT   = 2'd3;

    localparam logic signed [ACC_W-1:0] c_HALF = ACC_W'(2**(OUT_SHIFT-1));
    localparam logic signed [ACC_W-1:0] c_MAX  = ACC_W'(2**(DW-1)-1);
    localparam logic signed [ACC_W-1:0] c_MIN  = ~c_MAX;

    logic [1:0]                r_state;
    logic [MEM_SIZE*DW-1:0]    r_line;
    logic [KW*DW-1:0]          r_kernel;
    logic [MEM_ADDR-1:0]       r_p;
    logic [c_TW-1:0]           r_t;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [DW-1:0]      r_out_data;
    logic                      r_out_valid;
    logic                      r_done;
    logic                      r_busy;
    logic                      r_rd_en;

    logic signed [DW-1:0]      w_x [MEM_SIZE];
    logic signed [DW-1:0]      w_w [KW];
    logic [MEM_ADDR-1:0]       w_xi;
    logic signed [2*DW-1:0]    w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_rnd;
    logic signed [ACC_W-1:0]   w_shr;
    logic signed [DW-1:0]      w_sat;
    logic signed [DW-1:0]      w_res;

    // Element 0 of both buses sits in the most-significant word.
    for (genvar gi = 0; gi < MEM_SIZE; gi++) begin : g_line
        assign w_x[gi] = r_line[(MEM_SIZE-1-gi)*DW +: DW];
    end
    for (genvar gk = 0; gk < KW; gk++) begin : g_kernel
        assign w_w[gk] = r_kernel[(KW-1-gk)*DW +: DW];
    end

    assign w_xi       = r_p + MEM_ADDR'(r_t);
    assign w_prod     = w_x[w_xi] * w_w[r_t];
    assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;
    assign w_rnd      = w_sum + c_HALF;
    assign w_shr      = w_rnd >>> OUT_SHIFT;

    always_comb begin
        w_sat = w_shr[DW-1:0];
        if (w_shr > c_MAX) begin
            w_sat = c_MAX[DW-1:0];
        end else if (w_shr < c_MIN) begin
            w_sat = c_MIN[DW-1:0];
        end
    end

`ifdef RELU_EN
    assign w_res = w_sat[DW-1] ? '0 : w_sat;
`else
    assign w_res = w_sat;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_line      <= '0;
            r_kernel    <= '0;
            r_p         <= '0;
            r_t         <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_rd_en     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_FETCH;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                c_FETCH: begin
                    r_line   <= line_in;
                    r_kernel <= kernel_in;
                    r_p      <= '0;
                    r_t      <= '0;
                    r_acc    <= '0;
                    r_rd_en  <= 1'b0;
                    r_state  <= c_MAC;
                end
                c_MAC: begin
                    r_acc <= w_sum;
                    // The last tap's product is folded in combinationally so the
                    // result lands in the same edge that leaves MAC.
                    if (r_t == c_TW'(KW-1)) begin
                        r_t         <= '0;
                        r_out_data  <= w_res;
                        r_out_valid <= 1'b1;
                        r_state     <= c_OUT;
                    end else begin
                        r_t <= r_t + 1'b1;
                    end
                end
                c_OUT: begin
                    if (out_if.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_p == MEM_ADDR'(c_NOUT-1)) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= c_IDLE;
                        end else begin
                            r_p     <= r_p + 1'b1;
                            r_acc   <= '0;
                            r_state <= c_MAC;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign rd_en            = r_rd_en;
    assign busy             = r_busy;
    assign out_if.out_valid = r_out_valid;
    assign out_if.out_data  = r_out_data;
    assign out_if.out_idx   = r_p;
    assign out_if.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_conv1d_line_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv1d_line_mac
// Brief    : Self-checking bench for conv1d_line_mac (directed table, random
//            lines against a convolution model, back-pressure, reset abort).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv1d_line_mac;

    localparam int DW        = 16;
    localparam int MEM_SIZE  = 10;
    localparam int MEM_ADDR  = 4;
    localparam int KW        = 3;
    localparam int OUT_SHIFT = 8;
    localparam int NOUT      = MEM_SIZE - KW + 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [KW*DW-1:0]       kernel_in;
    logic [MEM_SIZE*DW-1:0] line_in;
    logic                   rd_en;
    logic                   busy;

    conv1d_line_mac_if #(.DW(DW), .MEM_ADDR(MEM_ADDR)) ifc ();

    conv1d_line_mac #(
        .DW(DW), .MEM_SIZE(MEM_SIZE), .MEM_ADDR(MEM_ADDR),
        .KW(KW), .OUT_SHIFT(OUT_SHIFT), .ACC_W(2*DW+4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .kernel_in(kernel_in),
        .rd_en(rd_en), .line_in(line_in), .busy(busy), .out_if(ifc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ln [MEM_SIZE];
    int kw [KW];

    typedef struct {
        string name;
        int    base;
        int    step;
        int    kval;
        int    exp_first;
        int    exp_last;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int relu(input int v);
`ifdef RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Plain convolution with round-half-up and saturation.
    function automatic int model(input int p);
        longint acc = 0;
        longint r;
        for (int t = 0; t < KW; t++) acc += longint'(ln[p+t]) * longint'(kw[t]);
        r = (acc + (longint'(1) << (OUT_SHIFT-1))) >>> OUT_SHIFT;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return relu(int'(r));
    endfunction

    // mode 0: always ready (latency checked); 1: random ready and start while busy;
    // 2: hold ready low for 5 cycles at idx 2.
    task automatic run_line(input int mode, input string tag, output int first_d, output int last_d);
        int  exp_d [NOUT];
        int  got = 0, cyc = 0, stall = 0, done_n = 0, last_hs = 0;
        bit  prev_stall = 1'b0;
        bit  r;
        longint held_d = 0, held_i = 0;
        first_d = 0;
        last_d  = 0;
        for (int i = 0; i < MEM_SIZE; i++) line_in[(MEM_SIZE-1-i)*DW +: DW] = DW'(ln[i]);
        for (int t = 0; t < KW; t++) kernel_in[(KW-1-t)*DW +: DW] = DW'(kw[t]);
        for (int p = 0; p < NOUT; p++) exp_d[p] = model(p);
        @(negedge clk);
        start = 1'b1;
        while (got < NOUT && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = (mode == 1 && busy) ? 1'($urandom % 2) : 1'b0;
            chk({tag, " rd_en"}, longint'(rd_en), longint'(cyc == 1));
            if (ifc.done) done_n++;
            if (ifc.out_valid) begin
                if (prev_stall) begin
                    chk({tag, " stall data"}, longint'(ifc.out_data), held_d);
                    chk({tag, " stall idx"}, longint'(ifc.out_idx), held_i);
                end
                if (mode == 1) r = ($urandom % 3) != 0;
                else if (mode == 2) r = !(ifc.out_idx == 2 && stall < 5);
                else r = 1'b1;
                if (!r && mode == 2) stall++;
                ifc.out_ready = r;
                if (r) begin
                    chk({tag, " idx"}, longint'(ifc.out_idx), got);
                    chk({tag, " data"}, longint'(ifc.out_data), exp_d[got]);
                    if (got == 0) begin
                        first_d = int'(ifc.out_data);
                        if (mode == 0) chk({tag, " first latency"}, cyc, KW+2);
                    end
                    last_d     = int'(ifc.out_data);
                    got++;
                    last_hs    = cyc;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    held_d     = longint'(ifc.out_data);
                    held_i     = longint'(ifc.out_idx);
                end
            end else begin
                ifc.out_ready = (mode == 1) ? 1'($urandom % 2) : 1'b1;
                prev_stall    = 1'b0;
            end
        end
        if (got < NOUT) begin
            chk({tag, " timeout results"}, got, NOUT);
        end else begin
            if (mode == 0) chk({tag, " line latency"}, last_hs, 1 + NOUT*(KW+1));
            if (mode == 2) chk({tag, " stall cycles"}, stall, 5);
            @(negedge clk);
            start         = 1'b0;
            ifc.out_ready = 1'b0;
            if (ifc.done) done_n++;
            chk({tag, " done pulse"}, longint'(ifc.done), 1);
            chk({tag, " busy after"}, longint'(busy), 0);
            chk({tag, " valid after"}, longint'(ifc.out_valid), 0);
            @(negedge clk);
            if (ifc.done) done_n++;
            chk({tag, " done count"}, done_n, 1);
        end
    endtask

    initial begin
        int fd, ld;
        bit found;
        logic signed [DW-1:0] rv;

        vecs[0] = '{"ramp",    0,      1,  256, 3,                24};
        vecs[1] = '{"round",   1,      0,  128, 2,                2};
        vecs[2] = '{"satpos",  32767,  0,  256, 32767,            32767};
        vecs[3] = '{"satneg",  -32768, 0,  256, relu(-32768),     relu(-32768)};
        vecs[4] = '{"neg100",  -100,   0,  256, relu(-300),       relu(-300)};
        vecs[5] = '{"halfneg", 1,      0,  -128, relu(-1),        relu(-1)};
        vecs[6] = '{"mixed",   5,      -3, 300, 7,                relu(-67)};

        reset         = 1'b0;
        start         = 1'b0;
        ifc.out_ready = 1'b0;
        line_in       = '0;
        kernel_in     = '0;
        repeat (2) @(negedge clk);
        chk("reset rd_en", longint'(rd_en), 0);
        chk("reset busy", longint'(busy), 0);
        chk("reset valid", longint'(ifc.out_valid), 0);
        chk("reset data", longint'(ifc.out_data), 0);
        chk("reset idx", longint'(ifc.out_idx), 0);
        chk("reset done", longint'(ifc.done), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < MEM_SIZE; i++) ln[i] = vecs[v].base + vecs[v].step * i;
            for (int t = 0; t < KW; t++) kw[t] = vecs[v].kval;
            run_line(0, vecs[v].name, fd, ld);
            chk({vecs[v].name, " first"}, fd, vecs[v].exp_first);
            chk({vecs[v].name, " last"}, ld, vecs[v].exp_last);
        end

        for (int i = 0; i < MEM_SIZE; i++) ln[i] = 1000 - 300 * i;
        kw[0] = 100; kw[1] = -50; kw[2] = 300;
        run_line(2, "backpressure", fd, ld);

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                rv    = DW'($urandom);
                ln[i] = int'(rv);
            end
            for (int t = 0; t < KW; t++) begin
                rv    = DW'($urandom);
                kw[t] = int'(rv);
            end
            run_line(1, "random", fd, ld);
        end

        // Abort during MAC of idx 4, then a clean line must follow.
        for (int i = 0; i < MEM_SIZE; i++) ln[i] = 10 * i + 7;
        for (int t = 0; t < KW; t++) kw[t] = 256;
        for (int i = 0; i < MEM_SIZE; i++) line_in[(MEM_SIZE-1-i)*DW +: DW] = DW'(ln[i]);
        for (int t = 0; t < KW; t++) kernel_in[(KW-1-t)*DW +: DW] = DW'(kw[t]);
        @(negedge clk);
        start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            start         = 1'b0;
            ifc.out_ready = 1'b1;
            if (!ifc.out_valid && busy && ifc.out_idx == 4) found = 1'b1;
        end
        chk("abort reached idx4", longint'(found), 1);
        #2 reset = 1'b0;
        #1;
        chk("abort rd_en", longint'(rd_en), 0);
        chk("abort busy", longint'(busy), 0);
        chk("abort valid", longint'(ifc.out_valid), 0);
        chk("abort data", longint'(ifc.out_data), 0);
        chk("abort idx", longint'(ifc.out_idx), 0);
        chk("abort done", longint'(ifc.done), 0);
        @(negedge clk);
        reset = 1'b1;
        run_line(0, "after abort", fd, ld);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
